// File: rtl/can_tx_scheduler.sv
// Four-mailbox CAN transmit scheduler: arbitrates by CAN priority and presents one frame to the sender.
// Build option CAN_TXS_RETRY_LIMIT_EN: drop a mailbox on its 16th transmission error.
module can_tx_scheduler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [1:0]  wr_sel,
  input  logic [28:0] wr_id,
  input  logic        wr_ext,
  input  logic        wr_rtr,
  input  logic [3:0]  wr_dlc,
  input  logic [63:0] wr_data,
  input  logic [3:0]  abort_req,
  input  logic        running_start,
  input  logic        transmission_error,
  input  logic        tx_done,
  output logic        msg_exists,
  output logic [28:0] msg_id,
  output logic        extended,
  output logic        rtr,
  output logic [3:0]  num_bytes,
  output logic [63:0] msg,
  output logic [3:0]  mb_busy,
  output logic        tx_ok,
  output logic        tx_fail,
  output logic [1:0]  evt_idx,
  output logic        wr_reject
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SELECT  = 2'd1;
  localparam logic [1:0] PRESENT = 2'd2;
  localparam logic [1:0] ACTIVE  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [1:0]  cur_idx_q, cur_idx_d;
  logic [3:0]  busy_q, busy_d;
  logic [3:0]  abort_pend_q, abort_pend_d;
  logic        msg_exists_q, msg_exists_d;
  logic        tx_ok_q, tx_ok_d;
  logic        tx_fail_q, tx_fail_d;
  logic        wr_reject_q, wr_reject_d;
  logic [1:0]  evt_idx_q, evt_idx_d;

  logic [28:0] fr_id_q;
  logic        fr_ext_q;
  logic        fr_rtr_q;
  logic [3:0]  fr_dlc_q;
  logic [63:0] fr_data_q;

  logic [28:0] mb_id_q   [4];
  logic [3:0]  mb_dlc_q  [4];
  logic [63:0] mb_data_q [4];
  logic [3:0]  mb_ext_q;
  logic [3:0]  mb_rtr_q;

  logic        wr_acc;
  logic        load_frame;
  logic        drop;
  logic        win_found;
  logic [1:0]  win_idx;
  logic [3:0]  avail;
  logic [29:0] best_key;
  logic [29:0] cand_key;

`ifdef CAN_TXS_RETRY_LIMIT_EN
  logic [3:0]  retry_q [4];
  logic        retry_inc;
`endif

  // Standard frames beat extended ones with the same base ID; low 18 bits only matter when extended.
  function automatic logic [29:0] prio_key(input logic [28:0] id, input logic ext);
    return {id[28:18], ext, ext ? id[17:0] : 18'b0};
  endfunction

  always_comb begin
    avail     = busy_q & ~abort_req;
    win_found = 1'b0;
    win_idx   = 2'd0;
    best_key  = '1;
    cand_key  = '0;
    for (int i = 0; i < 4; i++) begin
      cand_key = prio_key(mb_id_q[i], mb_ext_q[i]);
      if (avail[i] && (!win_found || cand_key < best_key)) begin
        win_found = 1'b1;
        win_idx   = 2'(i);
        best_key  = cand_key;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cur_idx_d    = cur_idx_q;
    busy_d       = busy_q;
    abort_pend_d = abort_pend_q;
    msg_exists_d = msg_exists_q;
    load_frame   = 1'b0;
    drop         = 1'b0;
    tx_ok_d      = 1'b0;
    tx_fail_d    = 1'b0;
    wr_acc       = wr_en & ~busy_q[wr_sel] & ~abort_req[wr_sel];
    wr_reject_d  = wr_en & ~wr_acc;
    evt_idx_d    = wr_reject_d ? wr_sel : 2'd0;
`ifdef CAN_TXS_RETRY_LIMIT_EN
    retry_inc    = 1'b0;
`endif

    // The frame on the bus cannot be pulled; its abort is remembered until the outcome.
    for (int i = 0; i < 4; i++) begin
      if (abort_req[i] && busy_q[i]) begin
        if (state_q == ACTIVE && cur_idx_q == 2'(i)) begin
          abort_pend_d[i] = 1'b1;
        end else begin
          busy_d[i]       = 1'b0;
          abort_pend_d[i] = 1'b0;
        end
      end
    end
    if (wr_acc) begin
      busy_d[wr_sel]       = 1'b1;
      abort_pend_d[wr_sel] = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (|busy_d) state_d = SELECT;
      end
      SELECT: begin
        if (win_found) begin
          cur_idx_d    = win_idx;
          load_frame   = 1'b1;
          msg_exists_d = 1'b1;
          state_d      = PRESENT;
        end else if (~|busy_d) begin
          state_d = IDLE;
        end
      end
      PRESENT: begin
        if (abort_req[cur_idx_q]) begin
          msg_exists_d = 1'b0;
          state_d      = SELECT;
        end else if (running_start) begin
          state_d = ACTIVE;
        end else begin
          cur_idx_d  = win_idx;
          load_frame = 1'b1;
        end
      end
      ACTIVE: begin
        if (transmission_error) begin
          drop = abort_pend_q[cur_idx_q] | abort_req[cur_idx_q];
`ifdef CAN_TXS_RETRY_LIMIT_EN
          retry_inc = 1'b1;
          drop      = drop | (retry_q[cur_idx_q] == 4'hF);
`endif
          msg_exists_d = 1'b0;
          if (drop) begin
            busy_d[cur_idx_q]       = 1'b0;
            abort_pend_d[cur_idx_q] = 1'b0;
            tx_fail_d               = 1'b1;
            evt_idx_d               = cur_idx_q;
          end
          state_d = (|busy_d) ? SELECT : IDLE;
        end else if (tx_done) begin
          busy_d[cur_idx_q]       = 1'b0;
          abort_pend_d[cur_idx_q] = 1'b0;
          tx_ok_d                 = 1'b1;
          evt_idx_d               = cur_idx_q;
          msg_exists_d            = 1'b0;
          state_d                 = (|busy_d) ? SELECT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cur_idx_q    <= 2'd0;
      busy_q       <= 4'd0;
      abort_pend_q <= 4'd0;
      msg_exists_q <= 1'b0;
      tx_ok_q      <= 1'b0;
      tx_fail_q    <= 1'b0;
      wr_reject_q  <= 1'b0;
      evt_idx_q    <= 2'd0;
      fr_id_q      <= 29'd0;
      fr_ext_q     <= 1'b0;
      fr_rtr_q     <= 1'b0;
      fr_dlc_q     <= 4'd0;
      fr_data_q    <= 64'd0;
    end else begin
      state_q      <= state_d;
      cur_idx_q    <= cur_idx_d;
      busy_q       <= busy_d;
      abort_pend_q <= abort_pend_d;
      msg_exists_q <= msg_exists_d;
      tx_ok_q      <= tx_ok_d;
      tx_fail_q    <= tx_fail_d;
      wr_reject_q  <= wr_reject_d;
      evt_idx_q    <= evt_idx_d;
      if (load_frame) begin
        fr_id_q   <= mb_id_q[cur_idx_d];
        fr_ext_q  <= mb_ext_q[cur_idx_d];
        fr_rtr_q  <= mb_rtr_q[cur_idx_d];
        fr_dlc_q  <= mb_dlc_q[cur_idx_d];
        fr_data_q <= mb_data_q[cur_idx_d];
      end
    end
  end

  // Mailbox contents are only meaningful while busy, so they need no reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mb_id_q[wr_sel]   <= wr_id;
      mb_ext_q[wr_sel]  <= wr_ext;
      mb_rtr_q[wr_sel]  <= wr_rtr;
      mb_dlc_q[wr_sel]  <= wr_dlc;
      mb_data_q[wr_sel] <= wr_data;
    end
  end

`ifdef CAN_TXS_RETRY_LIMIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) retry_q[i] <= 4'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (wr_acc && wr_sel == 2'(i)) retry_q[i] <= 4'd0;
        else if (retry_inc && cur_idx_q == 2'(i)) retry_q[i] <= retry_q[i] + 4'd1;
      end
    end
  end
`endif

  assign msg_exists = msg_exists_q;
  assign msg_id     = fr_id_q;
  assign extended   = fr_ext_q;
  assign rtr        = fr_rtr_q;
  assign num_bytes  = fr_dlc_q;
  assign msg        = fr_data_q;
  assign mb_busy    = busy_q;
  assign tx_ok      = tx_ok_q;
  assign tx_fail    = tx_fail_q;
  assign evt_idx    = evt_idx_q;
  assign wr_reject  = wr_reject_q;

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Self-checking bench for can_tx_scheduler: scenario tasks plus an event scoreboard for tx_ok/tx_fail.
module tb_can_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_sel = 2'd0;
  logic [28:0] wr_id = 29'd0;
  logic        wr_ext = 1'b0;
  logic        wr_rtr = 1'b0;
  logic [3:0]  wr_dlc = 4'd0;
  logic [63:0] wr_data = 64'd0;
  logic [3:0]  abort_req = 4'd0;
  logic        running_start = 1'b0;
  logic        transmission_error = 1'b0;
  logic        tx_done = 1'b0;
  logic        msg_exists;
  logic [28:0] msg_id;
  logic        extended;
  logic        rtr;
  logic [3:0]  num_bytes;
  logic [63:0] msg;
  logic [3:0]  mb_busy;
  logic        tx_ok;
  logic        tx_fail;
  logic [1:0]  evt_idx;
  logic        wr_reject;

  always #5 clk = ~clk;

  can_tx_scheduler dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_id(wr_id),
    .wr_ext(wr_ext), .wr_rtr(wr_rtr), .wr_dlc(wr_dlc), .wr_data(wr_data),
    .abort_req(abort_req), .running_start(running_start),
    .transmission_error(transmission_error), .tx_done(tx_done),
    .msg_exists(msg_exists), .msg_id(msg_id), .extended(extended), .rtr(rtr),
    .num_bytes(num_bytes), .msg(msg), .mb_busy(mb_busy), .tx_ok(tx_ok),
    .tx_fail(tx_fail), .evt_idx(evt_idx), .wr_reject(wr_reject)
  );

  typedef struct packed { logic fail; logic [1:0] idx; } ev_t;
  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  function automatic ev_t ev(input logic f, input logic [1:0] i);
    ev_t e;
    e.fail = f;
    e.idx  = i;
    return e;
  endfunction

  function automatic logic [28:0] sid(input logic [10:0] b);
    return {b, 18'b0};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load(input logic [1:0] sel, input logic [28:0] id, input logic ext,
                      input logic r, input logic [3:0] dlc, input logic [63:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_id = id; wr_ext = ext; wr_rtr = r; wr_dlc = dlc; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Scoreboard: every tx_ok/tx_fail pulse must match the next queued expectation.
  always @(negedge clk) begin
    ev_t e;
    if (tx_ok === 1'b1 || tx_fail === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL event_unexpected: got tx_ok=%0b tx_fail=%0b idx=%0d, required no event", tx_ok, tx_fail, evt_idx);
      end else begin
        e = exp_q.pop_front();
        if ({tx_fail, tx_ok, evt_idx} !== {e.fail, ~e.fail, e.idx}) begin
          n_err++;
          $display("FAIL event: got tx_ok=%0b tx_fail=%0b idx=%0d, required tx_ok=%0b tx_fail=%0b idx=%0d",
                   tx_ok, tx_fail, evt_idx, ~e.fail, e.fail, e.idx);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_cmp++; if (mb_busy !== 4'b0000) begin n_err++; $display("FAIL reset_busy: got %b, required 0000", mb_busy); end
    n_cmp++; if (msg_exists !== 1'b0) begin n_err++; $display("FAIL reset_msg_exists: got %b, required 0", msg_exists); end
    n_cmp++; if ({tx_ok, tx_fail, wr_reject, evt_idx} !== 5'd0) begin n_err++; $display("FAIL reset_events: got %b, required 00000", {tx_ok, tx_fail, wr_reject, evt_idx}); end
    n_cmp++; if (msg_id !== 29'd0) begin n_err++; $display("FAIL reset_msg_id: got %h, required 0", msg_id); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    load(2'd0, sid(11'h198), 1'b0, 1'b0, 4'd5, 64'h0BAD_C0FFEE);
    n_cmp++; if (mb_busy !== 4'b0001) begin n_err++; $display("FAIL basic_busy: got %b, required 0001", mb_busy); end
    n_cmp++; if (msg_exists !== 1'b0) begin n_err++; $display("FAIL basic_early: got %b, required 0", msg_exists); end
    tick();
    n_cmp++; if (msg_exists !== 1'b1) begin n_err++; $display("FAIL basic_latency: got %b, required 1", msg_exists); end
    n_cmp++; if (msg_id !== sid(11'h198)) begin n_err++; $display("FAIL basic_id: got %h, required %h", msg_id, sid(11'h198)); end
    n_cmp++; if (num_bytes !== 4'd5) begin n_err++; $display("FAIL basic_dlc: got %0d, required 5", num_bytes); end
    n_cmp++; if (msg !== 64'h0BAD_C0FFEE) begin n_err++; $display("FAIL basic_data: got %h, required 0badc0ffee", msg); end
    running_start = 1'b1; tick(); running_start = 1'b0;
    n_cmp++; if (msg_exists !== 1'b1 || msg_id !== sid(11'h198)) begin n_err++; $display("FAIL basic_active: got %b/%h, required 1/%h", msg_exists, msg_id, sid(11'h198)); end
    exp_q.push_back(ev(1'b0, 2'd0));
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    n_cmp++; if (mb_busy !== 4'b0000 || msg_exists !== 1'b0) begin n_err++; $display("FAIL basic_done: got busy=%b exists=%b, required 0000/0", mb_busy, msg_exists); end
    tick();
    n_cmp++; if (msg_exists !== 1'b0 || tx_ok !== 1'b0) begin n_err++; $display("FAIL basic_idle: got exists=%b tx_ok=%b, required 0/0", msg_exists, tx_ok); end
  endtask

  task automatic test_preempt();
    load(2'd2, sid(11'h300), 1'b0, 1'b0, 4'd8, 64'h2222);
    tick();
    n_cmp++; if (msg_exists !== 1'b1 || msg_id !== sid(11'h300)) begin n_err++; $display("FAIL preempt_first: got %b/%h, required 1/%h", msg_exists, msg_id, sid(11'h300)); end
    load(2'd1, sid(11'h100), 1'b0, 1'b1, 4'd0, 64'h1111);
    tick();
    n_cmp++; if (msg_id !== sid(11'h100) || rtr !== 1'b1 || msg_exists !== 1'b1) begin n_err++; $display("FAIL preempt_switch: got id=%h rtr=%b exists=%b, required %h/1/1", msg_id, rtr, msg_exists, sid(11'h100)); end
    running_start = 1'b1; tick(); running_start = 1'b0;
    exp_q.push_back(ev(1'b0, 2'd1));
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    n_cmp++; if (mb_busy !== 4'b0100 || msg_exists !== 1'b0) begin n_err++; $display("FAIL preempt_after: got busy=%b exists=%b, required 0100/0", mb_busy, msg_exists); end
    tick();
    n_cmp++; if (msg_exists !== 1'b1 || msg_id !== sid(11'h300)) begin n_err++; $display("FAIL preempt_next: got %b/%h, required 1/%h", msg_exists, msg_id, sid(11'h300)); end
    running_start = 1'b1; tick(); running_start = 1'b0;
    exp_q.push_back(ev(1'b0, 2'd2));
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    n_cmp++; if (mb_busy !== 4'b0000) begin n_err++; $display("FAIL preempt_empty: got %b, required 0000", mb_busy); end
  endtask

  task automatic test_priority();
    load(2'd0, 29'h0C0_0000, 1'b1, 1'b0, 4'd1, 64'hE0);
    load(2'd3, 29'h0C0_0000, 1'b0, 1'b0, 4'd3, 64'hE3);
    tick();
    n_cmp++; if (extended !== 1'b0 || msg !== 64'hE3 || msg_id !== 29'h0C0_0000) begin n_err++; $display("FAIL prio_std_wins: got ext=%b data=%h, required 0/e3", extended, msg); end
    running_start = 1'b1; tick(); running_start = 1'b0;
    exp_q.push_back(ev(1'b0, 2'd3));
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    tick();
    n_cmp++; if (msg_exists !== 1'b1 || extended !== 1'b1 || msg !== 64'hE0) begin n_err++; $display("FAIL prio_ext_next: got exists=%b ext=%b data=%h, required 1/1/e0", msg_exists, extended, msg); end
    running_start = 1'b1; tick(); running_start = 1'b0;
    exp_q.push_back(ev(1'b0, 2'd0));
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    load(2'd2, sid(11'h055), 1'b0, 1'b0, 4'd2, 64'h22);
    load(2'd1, sid(11'h055), 1'b0, 1'b0, 4'd2, 64'h11);
    tick();
    n_cmp++; if (msg !== 64'h11) begin n_err++; $display("FAIL prio_tie: got data=%h, required 11", msg); end
    running_start = 1'b1; tick(); running_start = 1'b0;
    exp_q.push_back(ev(1'b0, 2'd1));
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    tick();
    n_cmp++; if (msg !== 64'h22 || msg_exists !== 1'b1) begin n_err++; $display("FAIL prio_tie_next: got data=%h exists=%b, required 22/1", msg, msg_exists); end
    running_start = 1'b1; tick(); running_start = 1'b0;
    exp_q.push_back(ev(1'b0, 2'd2));
    tx_done = 1'b1; tick(); tx_done = 1'b0;
  endtask

  task automatic test_retry();
    load(2'd3, sid(11'h222), 1'b0, 1'b0, 4'd4, 64'h33);
    tick();
    for (int k = 0; k < 3; k++) begin
      running_start = 1'b1; tick(); running_start = 1'b0;
      transmission_error = 1'b1; tx_done = (k == 1); tick(); transmission_error = 1'b0; tx_done = 1'b0;
      n_cmp++; if (msg_exists !== 1'b0 || mb_busy !== 4'b1000) begin n_err++; $display("FAIL retry_gap%0d: got exists=%b busy=%b, required 0/1000", k, msg_exists, mb_busy); end
      tick();
      n_cmp++; if (msg_exists !== 1'b1 || msg_id !== sid(11'h222)) begin n_err++; $display("FAIL retry_again%0d: got %b/%h, required 1/%h", k, msg_exists, msg_id, sid(11'h222)); end
    end
    running_start = 1'b1; tick(); running_start = 1'b0;
    exp_q.push_back(ev(1'b0, 2'd3));
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    n_cmp++; if (mb_busy !== 4'b0000) begin n_err++; $display("FAIL retry_done: got %b, required 0000", mb_busy); end
  endtask

  task automatic test_retry_limit();
    load(2'd0, sid(11'h0AA), 1'b0, 1'b0, 4'd1, 64'hAA);
    tick();
    for (int k = 0; k < 16; k++) begin
      running_start = 1'b1; tick(); running_start = 1'b0;
`ifdef CAN_TXS_RETRY_LIMIT_EN
      if (k == 15) exp_q.push_back(ev(1'b1, 2'd0));
`endif
      transmission_error = 1'b1; tick(); transmission_error = 1'b0;
      tick();
    end
`ifdef CAN_TXS_RETRY_LIMIT_EN
    n_cmp++; if (mb_busy !== 4'b0000 || msg_exists !== 1'b0) begin n_err++; $display("FAIL limit_drop: got busy=%b exists=%b, required 0000/0", mb_busy, msg_exists); end
`else
    n_cmp++; if (mb_busy !== 4'b0001 || msg_exists !== 1'b1) begin n_err++; $display("FAIL limit_unlimited: got busy=%b exists=%b, required 0001/1", mb_busy, msg_exists); end
    running_start = 1'b1; tick(); running_start = 1'b0;
    exp_q.push_back(ev(1'b0, 2'd0));
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    n_cmp++; if (mb_busy !== 4'b0000) begin n_err++; $display("FAIL limit_done: got %b, required 0000", mb_busy); end
`endif
  endtask

  task automatic test_abort();
    load(2'd1, sid(11'h111), 1'b0, 1'b0, 4'd2, 64'h5151);
    tick();
    running_start = 1'b1; tick(); running_start = 1'b0;
    abort_req = 4'b0010; tick(); abort_req = 4'b0000;
    n_cmp++; if (mb_busy !== 4'b0010 || msg_exists !== 1'b1) begin n_err++; $display("FAIL abort_deferred: got busy=%b exists=%b, required 0010/1", mb_busy, msg_exists); end
    exp_q.push_back(ev(1'b1, 2'd1));
    transmission_error = 1'b1; tick(); transmission_error = 1'b0;
    n_cmp++; if (mb_busy !== 4'b0000 || msg_exists !== 1'b0) begin n_err++; $display("FAIL abort_fail: got busy=%b exists=%b, required 0000/0", mb_busy, msg_exists); end
    tick();
    load(2'd2, sid(11'h020), 1'b0, 1'b0, 4'd12, 64'hA5A5_0000_1234_5678);
    tick();
    n_cmp++; if (num_bytes !== 4'd12 || msg !== 64'hA5A5_0000_1234_5678) begin n_err++; $display("FAIL abort_dlc12: got dlc=%0d data=%h, required 12/a5a5000012345678", num_bytes, msg); end
    load(2'd2, sid(11'h7FF), 1'b1, 1'b1, 4'd1, 64'hDEAD);
    n_cmp++; if (wr_reject !== 1'b1 || evt_idx !== 2'd2) begin n_err++; $display("FAIL busy_write_reject: got rej=%b idx=%0d, required 1/2", wr_reject, evt_idx); end
    tick();
    n_cmp++; if (wr_reject !== 1'b0 || msg !== 64'hA5A5_0000_1234_5678 || msg_id !== sid(11'h020)) begin n_err++; $display("FAIL busy_write_kept: got rej=%b data=%h, required 0/a5a5000012345678", wr_reject, msg); end
    abort_req = 4'b0100; tick(); abort_req = 4'b0000;
    n_cmp++; if (mb_busy !== 4'b0000 || msg_exists !== 1'b0) begin n_err++; $display("FAIL abort_present: got busy=%b exists=%b, required 0000/0", mb_busy, msg_exists); end
    tick();
    wr_en = 1'b1; wr_sel = 2'd3; wr_id = sid(11'h001); abort_req = 4'b1000;
    tick();
    wr_en = 1'b0; abort_req = 4'b0000;
    n_cmp++; if (wr_reject !== 1'b1 || mb_busy !== 4'b0000) begin n_err++; $display("FAIL abort_and_write: got rej=%b busy=%b, required 1/0000", wr_reject, mb_busy); end
    tick();
    n_cmp++; if (msg_exists !== 1'b0 || mb_busy !== 4'b0000) begin n_err++; $display("FAIL abort_and_write_idle: got exists=%b busy=%b, required 0/0000", msg_exists, mb_busy); end
  endtask

  task automatic test_reset_active();
    load(2'd0, sid(11'h010), 1'b0, 1'b0, 4'd8, 64'h0101);
    load(2'd2, sid(11'h400), 1'b0, 1'b0, 4'd8, 64'h0202);
    n_cmp++; if (mb_busy !== 4'b0101 || msg_exists !== 1'b1 || msg_id !== sid(11'h010)) begin n_err++; $display("FAIL rstact_setup: got busy=%b exists=%b id=%h, required 0101/1/%h", mb_busy, msg_exists, msg_id, sid(11'h010)); end
    running_start = 1'b1; tick(); running_start = 1'b0;
    abort_req = 4'b0100; tick(); abort_req = 4'b0000;
    n_cmp++; if (mb_busy !== 4'b0001 || msg_exists !== 1'b1) begin n_err++; $display("FAIL abort_other: got busy=%b exists=%b, required 0001/1", mb_busy, msg_exists); end
    tx_done = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (msg_exists !== 1'b0 || mb_busy !== 4'b0000) begin n_err++; $display("FAIL rstact_async: got exists=%b busy=%b, required 0/0000", msg_exists, mb_busy); end
    n_cmp++; if (msg_id !== 29'd0 || msg !== 64'd0 || num_bytes !== 4'd0) begin n_err++; $display("FAIL rstact_frame: got id=%h data=%h dlc=%0d, required 0/0/0", msg_id, msg, num_bytes); end
    @(negedge clk);
    tx_done = 1'b0;
    n_cmp++; if (tx_ok !== 1'b0 || tx_fail !== 1'b0) begin n_err++; $display("FAIL rstact_pulse: got ok=%b fail=%b, required 0/0", tx_ok, tx_fail); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (mb_busy !== 4'b0000 || msg_exists !== 1'b0 || tx_ok !== 1'b0) begin n_err++; $display("FAIL rstact_after: got busy=%b exists=%b ok=%b, required 0000/0/0", mb_busy, msg_exists, tx_ok); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_preempt();
    test_priority();
    test_retry();
    test_retry_limit();
    test_abort();
    test_reset_active();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL events_outstanding: got %0d expected events never seen, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded 500000 time units, required completion");
    $fatal(1, "timeout");
  end

endmodule
